// File: rtl/fofb_pkg.sv
// Shared types and helpers for the FOFB calculation read sequencer.
package fofb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fofb_state_t;

    localparam logic [8:0] FOFB_CALC_LEN = 9'd479;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/fofb_sideband_pipe.sv
// Delay line carrying the stream sideband alongside the RAM/MAC pipeline.
module fofb_sideband_pipe #(
    parameter int ADDR_W = 9,
    parameter int CH_W   = 1,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              valid_i,
    input  logic              last_i,
    input  logic [CH_W-1:0]   user_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              valid_o,
    output logic              last_o,
    output logic [CH_W-1:0]   user_o,
    output logic [ADDR_W-1:0] addr_o
);
    localparam int W = 2 + CH_W + ADDR_W;

    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (en_i) begin
            stage_q[0] <= {valid_i, last_i, user_i, addr_i};
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign {valid_o, last_o, user_o, addr_o} = stage_q[DEPTH-1];

endmodule

// File: rtl/fofb_calc_seq.sv
// Per-frame RAM address sweep over all channels with an AXI-Stream sideband
// aligned to the read pipeline, plus busy/done/overrun status.
//
// state    | meaning
// ST_IDLE  | waiting for a start edge
// ST_RUN   | issuing addresses 0..len for each channel
// ST_DRAIN | all addresses issued, emptying the pipeline
module fofb_calc_seq
    import fofb_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int PIPE_LAT = 2,
    parameter int NUM_CH   = 2,
    localparam int CH_W    = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] calc_len,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    output logic [CH_W-1:0]   ram_ch,
    output logic [ADDR_W-1:0] addr_dly,
    output logic              m_tvalid,
    output logic              m_tlast,
    output logic [CH_W-1:0]   m_tuser,
    input  logic              m_tready,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic              overrun_sticky
);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    fofb_state_t       state_q, state_d;
    logic              start_q;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              sticky_q, sticky_d;
    logic              start_edge, advance, issue_valid, issue_last, final_accept;

    assign start_edge   = start & ~start_q;
    assign advance      = ~m_tvalid | m_tready;
    assign issue_valid  = (state_q == ST_RUN);
    assign issue_last   = (addr_q == len_q);
    assign final_accept = m_tvalid & m_tready & m_tlast & (m_tuser == LAST_CH);

    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DRAIN) & final_accept;
    assign overrun        = start_edge & busy;
    assign overrun_sticky = sticky_q;
    assign ram_en         = advance & busy;
    assign ram_addr       = addr_q;
    assign ram_ch         = ch_q;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        addr_d   = addr_q;
        ch_d     = ch_q;
        sticky_d = sticky_q | overrun;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_RUN;
                    len_d   = calc_len;
                    addr_d  = '0;
                    ch_d    = '0;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    if (issue_last) begin
                        addr_d = '0;
                        if (ch_q == LAST_CH) state_d = ST_DRAIN;
                        else                 ch_d    = ch_q + CH_W'(1);
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (final_accept) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // start_q follows start even in reset so a level held through reset is not an edge
    always_ff @(posedge clk) begin
        start_q <= start;
        if (reset) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            addr_q   <= '0;
            ch_q     <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            ch_q     <= ch_d;
            sticky_q <= sticky_d;
        end
    end

    fofb_sideband_pipe #(
        .ADDR_W (ADDR_W),
        .CH_W   (CH_W),
        .DEPTH  (PIPE_LAT)
    ) u_pipe (
        .clk     (clk),
        .reset   (reset),
        .en_i    (advance),
        .valid_i (issue_valid),
        .last_i  (issue_valid & issue_last),
        .user_i  (ch_q),
        .addr_i  (addr_q),
        .valid_o (m_tvalid),
        .last_o  (m_tlast),
        .user_o  (m_tuser),
        .addr_o  (addr_dly)
    );

endmodule
